// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - opcodes, width check and saturation constants for multi_channel_mac
package mac_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_MAC   = 2'd2,
        OP_CLEAR = 2'd3
    } opcode_t;

    // Widest accumulator the saturation helper can describe
    localparam int SAT_MAX_W = 128;

    // The accumulator must hold a full signed product without loss
    function automatic bit acc_width_ok(input int data_width, input int acc_width);
        return acc_width >= 2 * data_width;
    endfunction

    // Signed max (0x7F..F) or min (0x80..0) of an acc_width-bit value, zero-padded above
    function automatic logic [SAT_MAX_W-1:0] sat_value(input logic negative, input int acc_width);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < acc_width - 1) begin
                v[i] = ~negative;
            end else if (i == acc_width - 1) begin
                v[i] = negative;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/mac_multiplier.sv
// rtl/mac_multiplier.sv - signed DATA_WIDTH x DATA_WIDTH combinational multiplier
module mac_multiplier #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    output logic signed [2*DATA_WIDTH-1:0] product
);

    localparam int PW = 2 * DATA_WIDTH;

    // Widen both operands first so the product keeps every bit
    assign product = PW'(a) * PW'(b);

endmodule

// File: rtl/multi_channel_mac.sv
// rtl/multi_channel_mac.sv - pipelined multi-channel MAC; MAC_SATURATE_EN selects saturating overflow
module multi_channel_mac
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int CHANNELS   = 4,
    parameter int CH_W       = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         inValid,
    output logic                         inReady,
    input  logic [1:0]                   opcode,
    input  logic [CH_W-1:0]              channel,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic                         outValid,
    input  logic                         outReady,
    output logic [CH_W-1:0]              outChannel,
    output logic [ACC_WIDTH-1:0]         dataOut,
    output logic                         overflow
);

    localparam int PW = 2 * DATA_WIDTH;

    if (!acc_width_ok(DATA_WIDTH, ACC_WIDTH)) begin : g_acc_width_chk
        $error("multi_channel_mac: ACC_WIDTH must be at least 2*DATA_WIDTH");
    end
    if (CHANNELS < 2) begin : g_channels_chk
        $error("multi_channel_mac: CHANNELS must be at least 2");
    end

    logic                   stall;
    opcode_t                in_op;
    logic                   in_take;
    logic signed [PW-1:0]   product;

    logic                   s1_valid;
    opcode_t                s1_op;
    logic [CH_W-1:0]        s1_ch;
    logic signed [PW-1:0]   s1_data;

    logic signed [ACC_WIDTH-1:0] acc [CHANNELS];
    logic [CHANNELS-1:0]         ovf;

    logic signed [ACC_WIDTH-1:0] cur_acc;
    logic signed [ACC_WIDTH:0]   sum;
    logic                        sum_ovf;
    logic signed [ACC_WIDTH-1:0] new_acc;
    logic                        new_ovf;
`ifdef MAC_SATURATE_EN
    logic [SAT_MAX_W-1:0]        sat_full;
`endif

    // A result beat that is offered but not taken freezes the whole pipe
    assign stall   = outValid && !outReady;
    assign inReady = !stall;

    // NOPs and out-of-range channels are accepted but never enter the pipe
    assign in_op   = opcode_t'(opcode);
    assign in_take = inValid && (in_op != OP_NOP) && (int'(channel) < CHANNELS);

    mac_multiplier #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .a       (a),
        .b       (b),
        .product (product)
    );

    // S1: capture op, channel and either the product (MAC) or {a,b} (LOAD)
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOP;
            s1_ch    <= '0;
            s1_data  <= '0;
        end else if (!stall) begin
            s1_valid <= in_take;
            s1_op    <= in_op;
            s1_ch    <= channel;
            s1_data  <= (in_op == OP_LOAD) ? {a, b} : product;
        end
    end

    // S2: read the channel, apply the op and flag signed overflow of the MAC sum
    always_comb begin
        cur_acc = acc[s1_ch];
        sum     = (ACC_WIDTH+1)'(cur_acc) + (ACC_WIDTH+1)'(s1_data);
        sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        new_acc = cur_acc;
        new_ovf = ovf[s1_ch];
`ifdef MAC_SATURATE_EN
        sat_full = '0;
`endif
        case (s1_op)
            OP_LOAD: begin
                new_acc = ACC_WIDTH'(s1_data);
                new_ovf = 1'b0;
            end
            OP_CLEAR: begin
                new_acc = '0;
                new_ovf = 1'b0;
            end
            OP_MAC: begin
                new_ovf = ovf[s1_ch] | sum_ovf;
`ifdef MAC_SATURATE_EN
                sat_full = sat_value(sum[ACC_WIDTH], ACC_WIDTH);
                new_acc  = sum_ovf ? sat_full[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
`else
                new_acc  = sum[ACC_WIDTH-1:0];
`endif
            end
            default: ;
        endcase
    end

    // Accumulator and sticky-overflow write-back; visible to the very next S2 op
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ovf <= '0;
        end else if (!stall && s1_valid) begin
            acc[s1_ch] <= new_acc;
            ovf[s1_ch] <= new_ovf;
        end
    end

    // Output register: one beat per valid S2 op, held while the consumer stalls
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            outValid   <= 1'b0;
            outChannel <= '0;
            dataOut    <= '0;
            overflow   <= 1'b0;
        end else if (!stall) begin
            outValid <= s1_valid;
            if (s1_valid) begin
                outChannel <= s1_ch;
                dataOut    <= new_acc;
                overflow   <= new_ovf;
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_mac.sv
// tb/tb_multi_channel_mac.sv - randomized and directed self-checking bench for multi_channel_mac
module tb_multi_channel_mac;

    localparam int DW = 16;
    localparam int AW = 40;
    localparam int CH = 4;
    localparam int CW = 2;
    localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (AW - 1));

    logic                 clk = 1'b0;
    logic                 rstN;
    logic                 inValid;
    logic                 inReady;
    logic [1:0]           opcode;
    logic [CW-1:0]        channel;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic                 outValid;
    logic                 outReady = 1'b1;
    logic [CW-1:0]        outChannel;
    logic [AW-1:0]        dataOut;
    logic                 overflow;

    typedef struct {
        int            ch;
        logic [AW-1:0] data;
        logic          ovf;
    } beat_t;

    beat_t  exp_q[$];
    longint m_acc[CH];
    bit     m_ovf[CH];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic rand_ready = 1'b0;
    logic dir_ready  = 1'b1;

    logic [AW-1:0] last_data = '0, prev_data = '0;
    logic          last_ovf = 1'b0, prev_ovf = 1'b0;
    int            last_ch = 0, prev_ch = 0;
    int            last_cyc = 0, prev_cyc = 0;

    bit            prev_stall = 0;
    logic [AW-1:0] held_data;
    logic [CW-1:0] held_ch;
    logic          held_ovf;

    multi_channel_mac #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .CHANNELS   (CH)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .inValid    (inValid),
        .inReady    (inReady),
        .opcode     (opcode),
        .channel    (channel),
        .a          (a),
        .b          (b),
        .outValid   (outValid),
        .outReady   (outReady),
        .outChannel (outChannel),
        .dataOut    (dataOut),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        outReady = rand_ready ? ($urandom_range(0, 3) != 0) : dir_ready;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] to_acc(input longint v);
        logic [63:0] t;
        t = v;
        return t[AW-1:0];
    endfunction

    function automatic longint wrap_acc(input longint v);
        longint t;
        t = v & ((longint'(1) << AW) - 1);
        if (t > MAXV) t = t - (longint'(1) << AW);
        return t;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 0;
        end
        exp_q.delete();
    endfunction

    function automatic void model_op(input logic [1:0] op, input int ch,
                                     input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
        longint full;
        bit     o;
        beat_t  bt;
        case (op)
            2'd1: begin
                m_acc[ch] = longint'($signed({x, y}));
                m_ovf[ch] = 0;
            end
            2'd2: begin
                full = m_acc[ch] + longint'(x) * longint'(y);
                o = (full > MAXV) || (full < MINV);
                if (o) begin
`ifdef MAC_SATURATE_EN
                    m_acc[ch] = (full > MAXV) ? MAXV : MINV;
`else
                    m_acc[ch] = wrap_acc(full);
`endif
                end else begin
                    m_acc[ch] = full;
                end
                m_ovf[ch] = m_ovf[ch] | o;
            end
            2'd3: begin
                m_acc[ch] = 0;
                m_ovf[ch] = 0;
            end
            default: return;
        endcase
        bt.ch   = ch;
        bt.data = to_acc(m_acc[ch]);
        bt.ovf  = m_ovf[ch];
        exp_q.push_back(bt);
    endfunction

    always @(negedge clk) begin
        beat_t bt;
        if (rstN !== 1'b1) begin
            prev_stall = 0;
        end else begin
            check("inready_rule", inReady, !(outValid && !outReady));
            if (prev_stall) begin
                check("hold_valid", outValid, 1'b1);
                check("hold_data", dataOut, held_data);
                check("hold_ch", outChannel, held_ch);
                check("hold_ovf", overflow, held_ovf);
            end
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", outValid, 1'b0);
                end else begin
                    bt = exp_q.pop_front();
                    check("beat_ch", outChannel, bt.ch);
                    check("beat_data", dataOut, bt.data);
                    check("beat_ovf", overflow, bt.ovf);
                end
                prev_data = last_data; prev_ovf = last_ovf; prev_ch = last_ch; prev_cyc = last_cyc;
                last_data = dataOut;   last_ovf = overflow; last_ch = int'(outChannel); last_cyc = cyc;
            end
            if (inValid && inReady) model_op(opcode, int'(channel), a, b);
            prev_stall = outValid && !outReady;
            held_data  = dataOut;
            held_ch    = outChannel;
            held_ovf   = overflow;
        end
    end

    task automatic send(input logic [1:0] op, input int ch, input int av, input int bv);
        int n = 0;
        opcode  = op;
        channel = ch[CW-1:0];
        a       = av[DW-1:0];
        b       = bv[DW-1:0];
        inValid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!inReady && n < 200);
        if (!inReady) check("send_timeout", inReady, 1'b1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outvalid"}, outValid, 1'b0);
        check({tag, "_dataout"}, dataOut, '0);
        check({tag, "_outchannel"}, outChannel, '0);
        check({tag, "_overflow"}, overflow, 1'b0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN    = 1'b0;
        inValid = 1'b0;
        opcode  = 2'd0;
        channel = '0;
        a       = '0;
        b       = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_inready", inReady, 1'b1);
        rstN = 1'b1;

        // MAC ch0 3*4, two-cycle latency
        send(2'd2, 0, 3, 4);
        @(negedge clk);
        check("lat_early_valid", outValid, 1'b0);
        @(posedge clk);
        #1;
        check("lat_valid", outValid, 1'b1);
        check("lat_data", dataOut, 40'd12);
        check("lat_ch", outChannel, 2'd0);
        check("lat_ovf", overflow, 1'b0);
        drain();

        // three back-to-back MACs on ch1
        for (int i = 0; i < 3; i++) send(2'd2, 1, -2, 5);
        drain();
        check("b2b_prev", prev_data, to_acc(-20));
        check("b2b_last", last_data, to_acc(-30));
        check("b2b_consecutive", last_cyc - prev_cyc, 1);

        // LOAD then CLEAR on ch2
        send(2'd1, 2, 1, 2);
        drain();
        check("load_data", last_data, 40'h0000010002);
        send(2'd3, 2, 0, 0);
        drain();
        check("clear_data", last_data, 40'h0);
        check("clear_ovf", last_ovf, 1'b0);

        // output stall with two ops queued
        dir_ready = 1'b0;
        send(2'd2, 0, 2, 3);
        send(2'd2, 3, 4, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_inready", inReady, 1'b0);
            check("stall_valid", outValid, 1'b1);
        end
        @(posedge clk);
        #1;
        dir_ready = 1'b1;
        drain();
        check("stall_order_first", prev_ch, 0);
        check("stall_order_second", last_ch, 3);
        check("stall_data_first", prev_data, 40'd18);
        check("stall_data_second", last_data, 40'd20);

        // 512 MACs of (-32768)^2 on ch3
        send(2'd3, 3, 0, 0);
        for (int i = 0; i < 512; i++) send(2'd2, 3, -32768, -32768);
        drain();
        check("ovf_beat511_data", prev_data, 40'd511 << 30);
        check("ovf_beat511_flag", prev_ovf, 1'b0);
        check("ovf_beat512_flag", last_ovf, 1'b1);
`ifdef MAC_SATURATE_EN
        check("ovf_beat512_data", last_data, 40'h7FFFFFFFFF);
`else
        check("ovf_beat512_data", last_data, 40'h8000000000);
`endif

        // reset with two ops in flight
        send(2'd2, 0, 5, 5);
        send(2'd2, 2, 6, 6);
        rstN = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        check("midreset_inready", inReady, 1'b1);
        send(2'd2, 1, 1, 1);
        drain();
        check("after_reset_data", last_data, 40'd1);
        check("after_reset_ch", last_ch, 1);

        // randomized traffic with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                send(2'($urandom_range(0, 3)), int'($urandom_range(0, CH - 1)),
                     int'($urandom), int'($urandom));
            end
        end
        drain();
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
